// File: rtl/d2s_pkg.sv
// Shared types and constants for the deterministic-to-stochastic channel.
// LFSR tap masks, LFSR-B geometry and the frame state encoding.
package d2s_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INI,
    S_DEC,
    S_FIN
  } state_e;

  localparam int          LFSR_B_W    = 16;
  localparam logic [15:0] LFSR_B_TAPS = 16'hD008;

  // Maximal-length Fibonacci tap masks; bit (t-1) set for tap t.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] m;
    m = 16'h0000;
    case (width)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR with seed reload on the all-zero state.
// Only the low OUT_W bits are exported.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter int               OUT_W = WIDTH,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             fb;

  always_comb begin
    fb  = ^(q_q & TAPS);
    q_d = {q_q[WIDTH-2:0], fb};
    if (q_q == '0) begin
      q_d = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q[OUT_W-1:0];

endmodule

// File: rtl/d2s_channel.sv
// Channel stage: stochastic bit c, edge-memory address and the
// INIT / RUN / DONE frame sequencing for one equality node.
module d2s_channel
  import d2s_pkg::*;
#(
  parameter int          W        = 8,
  parameter int          EM_AW    = 3,
  parameter int          INIT_CYC = 16,
  parameter logic [15:0] SEED_A   = 16'h005A,
  parameter logic [15:0] SEED_B   = 16'hACE1
) (
  input  logic             CLK_D2S,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [W-1:0]     P_IN,
  input  logic [7:0]       NDEC,
  output logic             c,
  output logic [EM_AW-1:0] EM_SEL,
  output logic             INIT,
  output logic             RUN,
  output logic             DONE
);

  localparam int          IW     = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [W-1:0] TAPS_A = W'(lfsr_taps(W));

  state_e           state_q, state_d;
  logic [W-1:0]     p_q, p_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IW-1:0]    ini_q, ini_d;
  logic             c_q, c_d;
  logic             init_q, init_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [EM_AW-1:0] em_q, em_d;

  logic [W-1:0]     lfsr_a;
  logic [EM_AW-1:0] lfsr_b;

  lfsr_gen #(
    .WIDTH (W),
    .OUT_W (W),
    .SEED  (SEED_A[W-1:0]),
    .TAPS  (TAPS_A)
  ) u_lfsr_a (
    .clk (CLK_D2S),
    .rst (RST),
    .q   (lfsr_a)
  );

  lfsr_gen #(
    .WIDTH (LFSR_B_W),
    .OUT_W (EM_AW),
    .SEED  (SEED_B),
    .TAPS  (LFSR_B_TAPS)
  ) u_lfsr_b (
    .clk (CLK_D2S),
    .rst (RST),
    .q   (lfsr_b)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    ini_d   = ini_q;
    unique case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          state_d = S_INI;
          p_d     = P_IN;
          cnt_d   = NDEC;
          ini_d   = IW'(INIT_CYC - 1);
        end
      end
      S_INI: begin
        if (ini_q == '0) begin
          state_d = (cnt_q != 8'd0) ? S_DEC : S_FIN;
        end else begin
          ini_d = ini_q - 1'b1;
        end
      end
      S_DEC: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Compare uses the LFSR value of this cycle; c shows it next cycle.
    c_d    = ((state_q == S_INI) || (state_q == S_DEC)) && (lfsr_a < p_q);
    init_d = (state_d == S_INI);
    run_d  = (state_d == S_DEC);
    done_d = (state_d == S_FIN);
    em_d   = lfsr_b;
  end

  always_ff @(posedge CLK_D2S) begin
    if (RST) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      ini_q   <= '0;
      c_q     <= 1'b0;
      init_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      em_q    <= SEED_B[EM_AW-1:0];
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      ini_q   <= ini_d;
      c_q     <= c_d;
      init_q  <= init_d;
      run_q   <= run_d;
      done_q  <= done_d;
      em_q    <= em_d;
    end
  end

  assign c      = c_q;
  assign EM_SEL = em_q;
  assign INIT   = init_q;
  assign RUN    = run_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_d2s_channel.sv
// Randomized bench for d2s_channel against a frame-timeline model.
// The model tracks cycles since LOAD instead of FSM states.
module tb_d2s_channel;

  localparam logic [7:0]  SA = 8'h5A;
  localparam logic [15:0] SB = 16'hACE1;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] p_in;
  logic [7:0] ndec;
  logic       c;
  logic [2:0] em_sel;
  logic       init;
  logic       run;
  logic       done;

  int n_chk;
  int n_err;

  // model: mn = cycles since the LOAD edge (0 = idle)
  int         mn;
  int         mnd;
  logic [7:0] mp;
  logic [7:0] ma;
  logic [15:0] mb;
  logic       c_e;
  logic [2:0] em_e;

  int n_init;
  int n_run;
  int n_done;
  int ones;

  d2s_channel #(
    .W        (8),
    .EM_AW    (3),
    .INIT_CYC (16),
    .SEED_A   (16'h005A),
    .SEED_B   (SB)
  ) dut (
    .CLK_D2S (clk),
    .RST     (rst),
    .LOAD    (load),
    .P_IN    (p_in),
    .NDEC    (ndec),
    .c       (c),
    .EM_SEL  (em_sel),
    .INIT    (init),
    .RUN     (run),
    .DONE    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step_a(input logic [7:0] v);
    int   tp[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    if (v == 8'h00) return SA;
    foreach (tp[i]) fb = fb ^ v[tp[i]-1];
    return {v[6:0], fb};
  endfunction

  function automatic logic [15:0] step_b(input logic [15:0] v);
    int   tp[4] = '{16, 15, 13, 4};
    logic fb = 1'b0;
    if (v == 16'h0000) return SB;
    foreach (tp[i]) fb = fb ^ v[tp[i]-1];
    return {v[14:0], fb};
  endfunction

  task automatic model_edge();
    bit active;
    if (rst) begin
      mn   = 0;
      mp   = 8'h00;
      ma   = SA;
      mb   = SB;
      c_e  = 1'b0;
      em_e = SB[2:0];
    end else begin
      active = (mn >= 1) && (mn <= 16 + mnd);
      c_e    = active && (ma < mp);
      em_e   = mb[2:0];
      ma     = step_a(ma);
      mb     = step_b(mb);
      if (mn == 0) begin
        if (load) begin
          mn  = 1;
          mp  = p_in;
          mnd = int'(ndec);
        end
      end else if (mn >= 17 + mnd) begin
        mn = 0;
      end else begin
        mn++;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("c", c, c_e);
    chk("em_sel", em_sel, em_e);
    chk("init", init, (mn >= 1) && (mn <= 16));
    chk("run", run, (mn >= 17) && (mn <= 16 + mnd));
    chk("done", done, (mn != 0) && (mn == 17 + mnd));
    if (init) n_init++;
    if (run) n_run++;
    if (done) n_done++;
    if (run && c) ones++;
  endtask

  task automatic frame(input logic [7:0] p, input logic [7:0] nd,
                       input bit noise);
    int guard;
    guard  = 0;
    n_init = 0;
    n_run  = 0;
    n_done = 0;
    load   = 1'b1;
    p_in   = p;
    ndec   = nd;
    tick();
    load = 1'b0;
    while (mn != 0 && guard < 400) begin
      if (noise) begin
        load = 1'($urandom_range(0, 1));
        p_in = 8'($urandom);
        ndec = 8'($urandom);
      end
      tick();
      guard++;
    end
    load = 1'b0;
    chk("frame_timeout", guard < 400, 1);
    chk("init_len", n_init, 16);
    chk("run_len", n_run, nd);
    chk("done_len", n_done, 1);
  endtask

  initial begin
    int guard;
    n_chk = 0;
    n_err = 0;
    mnd   = 0;
    ones  = 0;
    rst   = 1'b1;
    load  = 1'b0;
    p_in  = 8'h00;
    ndec  = 8'h00;
    tick();
    chk("rst_em_sel", em_sel, 3'b001);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    frame(8'h80, 8'd100, 1'b0);

    ones = 0;
    for (int i = 0; i < 16; i++) frame(8'h80, 8'd255, 1'b0);
    chk("ones_band", (ones >= 1979) && (ones <= 2101), 1);

    ones = 0;
    frame(8'h00, 8'd50, 1'b0);
    chk("p0_ones", ones, 0);
    frame(8'hFF, 8'd50, 1'b0);
    frame(8'h3C, 8'd0, 1'b0);
    frame(8'h40, 8'd30, 1'b1);
    frame(8'hC0, 8'd1, 1'b1);

    load = 1'b1;
    p_in = 8'h90;
    ndec = 8'd40;
    tick();
    load  = 1'b0;
    guard = 0;
    while (mn != 21 && guard < 100) begin
      tick();
      guard++;
    end
    chk("dec5_reached", run, 1);
    rst  = 1'b1;
    load = 1'b1;
    p_in = 8'h11;
    tick();
    chk("rst_run", run, 0);
    chk("rst_em", em_sel, SB[2:0]);
    rst  = 1'b0;
    load = 1'b0;
    tick();
    chk("rst_idle_init", init, 0);
    frame(8'h70, 8'd20, 1'b0);

    for (int f = 0; f < 30; f++) begin
      frame(8'($urandom), 8'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      if ($urandom_range(0, 4) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
